// File: rtl/arbitro_bus_tri.sv
// Round-robin owner select for the shared 16-bit tristate bus, with a one-cycle all-off turnaround.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module arbitro_bus_tri #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] SEL,
    output logic [1:0] GNT_ID,
    output logic       BUSY,
    output logic       TIMEOUT,
    output logic [1:0] DBG_STATE
);
    // REQ is a level: the owner keeps its bit high while it needs the bus; SEL[i] high means master i drives.
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arbitro_bus_tri: MAX_HOLD must be in 2..255");
    end

    state_t     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win, idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // Scan offsets high to low so the nearest request after ptr is the last one written.
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (REQ[idx]) win = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE, TURN: begin
                sel_d   = 4'b0000;
                state_d = IDLE;
                if (REQ != 4'b0000) begin
                    state_d = GRANT;
                    sel_d   = 4'b0001 << win;
                    gnt_d   = win;
                    ptr_d   = win + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                hold_d = hold_q + 8'd1;
`endif
                if (!REQ[gnt_q]) begin
                    state_d = TURN;
                    sel_d   = 4'b0000;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d   = TURN;
                    sel_d     = 4'b0000;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                sel_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= 4'b0000;
            gnt_q   <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign SEL       = sel_q;
    assign GNT_ID    = gnt_q;
    assign BUSY      = |sel_q;
    assign DBG_STATE = state_q;
`ifdef ARB_TIMEOUT_EN
    assign TIMEOUT   = timeout_q;
`else
    assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_bus_tri.sv
// Bench for arbitro_bus_tri: directed vector table, hand sequences, then randomized REQ against a reference model.
module tb_arbitro_bus_tri;
`ifdef ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 4;
    localparam bit TO_EN    = 1'b1;
    localparam int SR_LEN   = 4;
`else
    localparam int MAX_HOLD = 16;
    localparam bit TO_EN    = 1'b0;
    localparam int SR_LEN   = 5;
`endif
    localparam int N_RAND = 10000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = 4'b0000;
    logic [3:0] SEL;
    logic [1:0] GNT_ID;
    logic       BUSY;
    logic       TIMEOUT;
    logic [1:0] DBG_STATE;

    arbitro_bus_tri #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .SEL(SEL), .GNT_ID(GNT_ID),
        .BUSY(BUSY), .TIMEOUT(TIMEOUT), .DBG_STATE(DBG_STATE)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sel;
        logic [1:0] gnt;
        logic       to;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // reference model: owner index (-1 none), last owner, pointer, cycles owned so far
    int   m_owner = -1;
    int   m_last  = 0;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    task automatic model_step(input logic rst, input logic [3:0] req);
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) m_owner = -1;
            else if (TO_EN && m_hold == MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else m_hold++;
        end else if (req != 4'd0) begin
            for (int d = 0; d < 4; d++) begin
                if (req[(m_ptr + d) % 4]) begin
                    m_owner = (m_ptr + d) % 4;
                    break;
                end
            end
            m_last = m_owner;
            m_ptr  = (m_owner + 1) % 4;
            m_hold = 1;
        end
        exp_q.push_back({m_to, (m_owner >= 0), 2'(m_last),
                         (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0});
    endtask

    // driver: change inputs on the falling edge, sample outputs 1 time unit after the rising edge
    task automatic cycle(input logic rst, input logic [3:0] req);
        @(negedge CLK);
        RST = rst;
        REQ = req;
        @(posedge CLK);
        model_step(rst, req);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] sel,
                                input logic [1:0] gnt, input logic to);
        vec_t v;
        v.rst = rst; v.req = req; v.sel = sel; v.gnt = gnt; v.to = to;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs();
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d_sel", i), SEL, vecs[i].sel);
            check($sformatf("vec%0d_gnt", i), 4'(GNT_ID), 4'(vecs[i].gnt));
            check($sformatf("vec%0d_busy", i), 4'(BUSY), 4'(vecs[i].sel != 4'd0));
            check($sformatf("vec%0d_timeout", i), 4'(TIMEOUT), 4'(vecs[i].to));
            if (vecs[i].rst) check($sformatf("vec%0d_state", i), 4'(DBG_STATE), 4'd0);
        end
        vecs.delete();
    endtask

    initial begin
        logic [7:0] e;
        logic [3:0] prev_sel;
        logic [3:0] rq;
        logic       rr;

        // reset with all requests high, first grant to master 0
        add(1, 4'b1111, 4'b0000, 0, 0);
        add(1, 4'b1111, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b0001, 0, 0);
        add(0, 4'b1110, 4'b0000, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        // single request for master 2, then pointer sits at 3
        for (int i = 0; i < SR_LEN; i++) add(0, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0000, 4'b0000, 2, 0);
        add(0, 4'b0000, 4'b0000, 2, 0);
        add(0, 4'b1111, 4'b1000, 3, 0);
        add(0, 4'b0111, 4'b0000, 3, 0);
        add(0, 4'b0000, 4'b0000, 3, 0);
        // round robin 0,1,2,3,0 with one off cycle between owners
        add(0, 4'b1111, 4'b0001, 0, 0);
        add(0, 4'b1110, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b0010, 1, 0);
        add(0, 4'b1101, 4'b0000, 1, 0);
        add(0, 4'b1111, 4'b0100, 2, 0);
        add(0, 4'b1011, 4'b0000, 2, 0);
        add(0, 4'b1111, 4'b1000, 3, 0);
        add(0, 4'b0111, 4'b0000, 3, 0);
        add(0, 4'b1111, 4'b0001, 0, 0);
        add(0, 4'b1110, 4'b0000, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        // reset mid-grant: no turnaround owed afterwards
        add(0, 4'b0010, 4'b0010, 1, 0);
        add(1, 4'b0010, 4'b0000, 0, 0);
        add(0, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 0);
        run_vecs();

`ifdef ARB_TIMEOUT_EN
        // forced release alternating between masters 0 and 1, then a release that coincides with the timeout
        add(1, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0001, 0, 0);
        add(0, 4'b0011, 4'b0000, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0010, 1, 0);
        add(0, 4'b0011, 4'b0000, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0001, 0, 0);
        add(0, 4'b0010, 4'b0000, 0, 0);
        add(0, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 0);
`else
        // no timeout: a held request keeps the bus indefinitely
        add(1, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 300; i++) add(0, 4'b0001, 4'b0001, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
`endif
        run_vecs();

        // randomized phase against the reference model
        exp_q.delete();
        prev_sel = SEL;
        for (int n = 0; n < N_RAND; n++) begin
            rr = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) rq = 4'b0000;
            cycle(rr, rq);
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rand_queue: expected queue empty at cycle %0d", n);
            end else begin
                e = exp_q.pop_front();
                check("rand_sel", SEL, e[3:0]);
                check("rand_gnt", 4'(GNT_ID), 4'(e[5:4]));
                check("rand_busy", 4'(BUSY), 4'(e[6]));
                check("rand_timeout", 4'(TIMEOUT), 4'(e[7]));
            end
            check("rand_onehot0", 4'($onehot0(SEL)), 4'd1);
            check("rand_gap", 4'((prev_sel != 4'd0) && (SEL != 4'd0) && (SEL != prev_sel)), 4'd0);
            prev_sel = SEL;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
